// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-bus AHB-Lite master: FSM states,
// HTRANS codes, request size codes and the alignment check.
package msrv32_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10,
    StErr  = 2'b11
  } dbus_state_e;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  // Half at an odd address, or word not on a 4-byte boundary. Code 11 is treated as word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_wdata_align.sv
// Store-lane replication: byte to all four lanes, half to both halves, word as is.
module msrv32_wdata_align (
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] hwdata_o
);
  import msrv32_pkg::*;

  // Replicate the store data so the slave can pick the lane by address.
  always_comb begin
    hwdata_o = wdata_i;
    case (size_i)
      SizeByte: hwdata_o = {4{wdata_i[7:0]}};
      SizeHalf: hwdata_o = {2{wdata_i[15:0]}};
      SizeWord: hwdata_o = wdata_i;
      default:  hwdata_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/msrv32_dbus_ahb.sv
// msrv32 data-bus master: turns one core load/store request at a time into a
// single AHB-Lite NONSEQ transfer and feeds the load unit.
// Optional: MSRV32_DBUS_MISALIGN_CHK_EN rejects misaligned half/word requests
// without a bus transfer; otherwise the address is forced to size alignment.
module msrv32_dbus_ahb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  input  logic              req_write_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [31:0]       req_wdata_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  output logic              req_ready_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic [1:0]        htrans_out,
  output logic              hwrite_out,
  output logic [2:0]        hsize_out,
  output logic [DATA_W-1:0] hwdata_out,
  input  logic [DATA_W-1:0] hrdata_in,
  input  logic              hready_in,
  input  logic              hresp_in,
  output logic [DATA_W-1:0] lu_data_out,
  output logic [1:0]        lu_size_out,
  output logic              lu_unsigned_out,
  output logic [1:0]        lu_addr_1_0_out,
  output logic              lu_resp_out,
  output logic              done_out,
  output logic              bus_err_out,
  output logic              misaligned_out
);
  import msrv32_pkg::*;

  dbus_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [DATA_W-1:0] lu_data_q, lu_data_d;
  logic              lu_resp_q, lu_resp_d;
  logic              done_q, done_d;
  logic              bus_err_q, bus_err_d;
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
  logic              mis_q, mis_d;
`endif

  msrv32_wdata_align u_wdata_align (
    .size_i  (size_q),
    .wdata_i (wdata_q),
    .hwdata_o(hwdata_out)
  );

  // Next-state, request capture and completion pulses.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_lo_d = addr_lo_q;
    lu_data_d = lu_data_q;
    lu_resp_d = 1'b1;
    done_d    = 1'b0;
    bus_err_d = 1'b0;
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
    mis_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_in) begin
          write_d   = req_write_in;
          wdata_d   = req_wdata_in;
          size_d    = req_size_in;
          uns_d     = req_unsigned_in;
          addr_lo_d = req_addr_in[1:0];
          addr_d    = req_addr_in;
          // Bus address is always size-aligned; the load unit keeps the raw low bits.
          case (req_size_in)
            SizeByte: addr_d = req_addr_in;
            SizeHalf: addr_d[0] = 1'b0;
            default:  addr_d[1:0] = 2'b00;
          endcase
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
          if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d = StAddr;
          end
`else
          state_d = StAddr;
`endif
        end
      end
      StAddr: begin
        if (hready_in) state_d = StData;
      end
      StData: begin
        if (hready_in) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (hresp_in) begin
            bus_err_d = 1'b1;
          end else if (!write_q) begin
            lu_data_d = hrdata_in;
            lu_resp_d = 1'b0;
          end
        end else if (hresp_in) begin
          state_d = StErr;
        end
      end
      StErr: begin
        if (hready_in) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
      lu_data_q <= '0;
      lu_resp_q <= 1'b1;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_lo_q <= addr_lo_d;
      lu_data_q <= lu_data_d;
      lu_resp_q <= lu_resp_d;
      done_q    <= done_d;
      bus_err_q <= bus_err_d;
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Outputs derived from registered state only.
  always_comb begin
    req_ready_out   = (state_q == StIdle);
    htrans_out      = (state_q == StAddr) ? HtransNonseq : HtransIdle;
    haddr_out       = addr_q;
    hwrite_out      = write_q;
    hsize_out       = {1'b0, size_q};
    lu_data_out     = lu_data_q;
    lu_size_out     = size_q;
    lu_unsigned_out = uns_q;
    lu_addr_1_0_out = addr_lo_q;
    lu_resp_out     = lu_resp_q;
    done_out        = done_q;
    bus_err_out     = bus_err_q;
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
    misaligned_out  = mis_q;
`else
    misaligned_out  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_msrv32_dbus_ahb.sv
// Self-checking bench for msrv32_dbus_ahb: directed scenarios plus randomized
// transfers checked against a cycle-count/transaction reference model.
module tb_msrv32_dbus_ahb;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        req_valid_in, req_write_in, req_unsigned_in;
  logic [31:0] req_addr_in, req_wdata_in;
  logic [1:0]  req_size_in;
  logic        req_ready_out;
  logic [31:0] haddr_out, hwdata_out, hrdata_in, lu_data_out;
  logic [1:0]  htrans_out, lu_size_out, lu_addr_1_0_out;
  logic        hwrite_out, hready_in, hresp_in;
  logic [2:0]  hsize_out;
  logic        lu_unsigned_out, lu_resp_out, done_out, bus_err_out, misaligned_out;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_lu_data = 32'h0;

  msrv32_dbus_ahb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_write_in(req_write_in), .req_addr_in(req_addr_in),
    .req_wdata_in(req_wdata_in), .req_size_in(req_size_in), .req_unsigned_in(req_unsigned_in),
    .req_ready_out(req_ready_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hwdata_out(hwdata_out),
    .hrdata_in(hrdata_in), .hready_in(hready_in), .hresp_in(hresp_in),
    .lu_data_out(lu_data_out), .lu_size_out(lu_size_out), .lu_unsigned_out(lu_unsigned_out),
    .lu_addr_1_0_out(lu_addr_1_0_out), .lu_resp_out(lu_resp_out),
    .done_out(done_out), .bus_err_out(bus_err_out), .misaligned_out(misaligned_out)
  );

  always #5 clk_in = ~clk_in;

  // One request through the bus. aw/dw are address/data wait states; err gives a
  // two-cycle ERROR response. Outputs sampled on negedges; cycle k is N+k.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit uns, input int aw, input int dw,
                          input bit err, input logic [31:0] rdata, input string tag);
    logic [31:0] exp_addr, exp_wdata, exp_lu;
    int          done_k;
    bit          in_addr, in_data, fin;
    exp_addr = addr - (addr % (32'd1 << size));
    case (size)
      2'd0:    exp_wdata = {24'd0, wdata[7:0]} * 32'h01010101;
      2'd1:    exp_wdata = {16'd0, wdata[15:0]} * 32'h00010001;
      default: exp_wdata = wdata;
    endcase
    done_k = 3 + aw + dw + (err ? 1 : 0);
    @(negedge clk_in);
    total++;
    if (req_ready_out !== 1'b1) begin
      bad++; $display("FAIL %s ready: got %b want 1", tag, req_ready_out);
    end
    req_valid_in = 1'b1; req_write_in = wr; req_addr_in = addr; req_wdata_in = wdata;
    req_size_in = size; req_unsigned_in = uns;
    hready_in = 1'($urandom); hresp_in = 1'($urandom); hrdata_in = $urandom;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk_in);
      if (k == 1) req_valid_in = 1'b0;
      in_addr = (k <= 1 + aw);
      in_data = (k >= 2 + aw) && (k <= 2 + aw + dw);
      fin = (k == done_k);
      exp_lu = (fin && !wr && !err) ? rdata : model_lu_data;
      total++;
      if (htrans_out !== (in_addr ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL %s htrans k=%0d: got %b", tag, k, htrans_out);
      end
      if (in_addr) begin
        total++;
        if (haddr_out !== exp_addr || hsize_out !== {1'b0, size} || hwrite_out !== wr) begin
          bad++;
          $display("FAIL %s addr phase k=%0d: got %h/%b/%b want %h/%b/%b", tag, k, haddr_out,
                   hsize_out, hwrite_out, exp_addr, {1'b0, size}, wr);
        end
      end
      if (in_data && wr) begin
        total++;
        if (hwdata_out !== exp_wdata) begin
          bad++; $display("FAIL %s hwdata k=%0d: got %h want %h", tag, k, hwdata_out, exp_wdata);
        end
      end
      total++;
      if (done_out !== fin || bus_err_out !== (fin && err) || req_ready_out !== fin) begin
        bad++;
        $display("FAIL %s done/err/ready k=%0d: got %b%b%b want %b%b%b", tag, k, done_out,
                 bus_err_out, req_ready_out, fin, fin && err, fin);
      end
      total++;
      if (lu_resp_out !== !(fin && !err && !wr)) begin
        bad++; $display("FAIL %s lu_resp k=%0d: got %b", tag, k, lu_resp_out);
      end
      total++;
      if (lu_data_out !== exp_lu) begin
        bad++; $display("FAIL %s lu_data k=%0d: got %h want %h", tag, k, lu_data_out, exp_lu);
      end
      total++;
      if (lu_size_out !== size || lu_unsigned_out !== uns || lu_addr_1_0_out !== addr[1:0] ||
          misaligned_out !== 1'b0) begin
        bad++;
        $display("FAIL %s lu fields k=%0d: got %b/%b/%b mis=%b", tag, k, lu_size_out,
                 lu_unsigned_out, lu_addr_1_0_out, misaligned_out);
      end
      // Bus inputs for the edge that ends cycle k.
      if (in_addr) begin
        hready_in = (k == 1 + aw); hresp_in = 1'($urandom); hrdata_in = $urandom;
      end else if (in_data) begin
        if (err) begin
          hready_in = 1'b0; hresp_in = (k == 2 + aw + dw);
        end else begin
          hready_in = (k == 2 + aw + dw); hresp_in = 1'b0;
        end
        hrdata_in = hready_in ? rdata : $urandom;
      end else if (err && k == 3 + aw + dw) begin
        hready_in = 1'b1; hresp_in = 1'b1; hrdata_in = $urandom;
      end else begin
        hready_in = 1'($urandom); hresp_in = 1'($urandom); hrdata_in = $urandom;
      end
    end
    if (!wr && !err) model_lu_data = rdata;
  endtask

  task automatic test_reset();
    logic [110:0] got;
    rst_n_in = 1'b0; req_valid_in = 1'b1; req_write_in = 1'b1; req_addr_in = $urandom;
    req_wdata_in = $urandom; req_size_in = 2'b10; req_unsigned_in = 1'b1;
    hready_in = 1'b1; hresp_in = 1'b1; hrdata_in = $urandom;
    repeat (3) @(negedge clk_in);
    got = {htrans_out, haddr_out, hwrite_out, hsize_out, hwdata_out, lu_data_out, lu_size_out,
           lu_unsigned_out, lu_addr_1_0_out, lu_resp_out, done_out, bus_err_out, misaligned_out};
    total++;
    if (got !== 111'd8) begin
      bad++; $display("FAIL reset outputs: got %h want %h", got, 111'd8);
    end
    total++;
    if (req_ready_out !== 1'b1) begin
      bad++; $display("FAIL reset ready: got %b want 1", req_ready_out);
    end
    req_valid_in = 1'b0; hresp_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_lu_data = 32'h0;
    @(negedge clk_in);
    total++;
    if (done_out !== 1'b0 || htrans_out !== 2'b00) begin
      bad++; $display("FAIL post-reset idle: got done=%b htrans=%b", done_out, htrans_out);
    end
  endtask

  task automatic test_load_word();
    run_xfer(1'b0, 32'h100, $urandom, 2'b10, 1'b0, 0, 0, 1'b0, 32'h12345678, "ld_word");
    @(negedge clk_in);
    total++;
    if (lu_data_out !== 32'h12345678 || lu_resp_out !== 1'b1 || done_out !== 1'b0) begin
      bad++;
      $display("FAIL ld_word retain: got %h resp=%b done=%b", lu_data_out, lu_resp_out, done_out);
    end
  endtask

  task automatic test_byte_wait();
    run_xfer(1'b0, 32'h101, $urandom, 2'b00, 1'b1, 0, 2, 1'b0, 32'h000000A5, "ld_byte_wait");
    @(negedge clk_in);
    total++;
    if (lu_addr_1_0_out !== 2'b01 || lu_unsigned_out !== 1'b1 || lu_size_out !== 2'b00) begin
      bad++;
      $display("FAIL ld_byte hold: got addr=%b uns=%b size=%b want 01/1/00", lu_addr_1_0_out,
               lu_unsigned_out, lu_size_out);
    end
  endtask

  task automatic test_store_half();
    run_xfer(1'b1, 32'h202, {16'h1357, 16'hBEEF}, 2'b01, 1'b0, 1, 0, 1'b0, $urandom, "st_half");
    @(negedge clk_in);
    total++;
    if (lu_data_out !== 32'h000000A5) begin
      bad++; $display("FAIL st_half lu_data: got %h want 000000a5", lu_data_out);
    end
  endtask

  task automatic test_error();
    run_xfer(1'b0, 32'h300, $urandom, 2'b10, 1'b0, 0, 0, 1'b1, 32'hFFFF0000, "ld_err");
    @(negedge clk_in);
    total++;
    if (lu_data_out !== 32'h000000A5 || bus_err_out !== 1'b0 || lu_resp_out !== 1'b1) begin
      bad++;
      $display("FAIL ld_err after: got %h err=%b resp=%b", lu_data_out, bus_err_out, lu_resp_out);
    end
  endtask

  task automatic test_misalign();
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
    @(negedge clk_in);
    total++;
    if (req_ready_out !== 1'b1) begin
      bad++; $display("FAIL misalign ready: got %b want 1", req_ready_out);
    end
    req_valid_in = 1'b1; req_write_in = 1'b0; req_addr_in = 32'h103; req_size_in = 2'b10;
    req_unsigned_in = 1'b0; hready_in = 1'b1; hresp_in = 1'b0;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    total++;
    if (misaligned_out !== 1'b1 || done_out !== 1'b1 || lu_resp_out !== 1'b1 ||
        htrans_out !== 2'b00 || bus_err_out !== 1'b0 || lu_addr_1_0_out !== 2'b11) begin
      bad++;
      $display("FAIL misalign N+1: got mis=%b done=%b resp=%b htrans=%b err=%b lo=%b",
               misaligned_out, done_out, lu_resp_out, htrans_out, bus_err_out, lu_addr_1_0_out);
    end
    @(negedge clk_in);
    total++;
    if (misaligned_out !== 1'b0 || done_out !== 1'b0 || htrans_out !== 2'b00 ||
        lu_data_out !== model_lu_data) begin
      bad++;
      $display("FAIL misalign N+2: got mis=%b done=%b htrans=%b data=%h", misaligned_out,
               done_out, htrans_out, lu_data_out);
    end
`else
    run_xfer(1'b0, 32'h103, $urandom, 2'b10, 1'b0, 0, 0, 1'b0, 32'h55AA55AA, "ld_misalign");
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
`ifdef MSRV32_DBUS_MISALIGN_CHK_EN
      a = a - (a % (32'd1 << sz));
`endif
      run_xfer(1'($urandom), a, $urandom, sz, 1'($urandom), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), $urandom, "rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [110:0] got;
    @(negedge clk_in);
    req_valid_in = 1'b1; req_write_in = 1'b0; req_addr_in = 32'h440; req_size_in = 2'b10;
    req_unsigned_in = 1'b0; hready_in = 1'b1; hresp_in = 1'b0;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    total++;
    if (htrans_out !== 2'b10) begin
      bad++; $display("FAIL rst_mid addr phase: got htrans=%b want 10", htrans_out);
    end
    @(negedge clk_in);
    hrdata_in = 32'hCAFEF00D; hready_in = 1'b1;
    rst_n_in = 1'b0;
    #1;
    got = {htrans_out, haddr_out, hwrite_out, hsize_out, hwdata_out, lu_data_out, lu_size_out,
           lu_unsigned_out, lu_addr_1_0_out, lu_resp_out, done_out, bus_err_out, misaligned_out};
    total++;
    if (got !== 111'd8) begin
      bad++; $display("FAIL rst_mid outputs: got %h want %h", got, 111'd8);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      total++;
      if (done_out !== 1'b0 || lu_data_out !== 32'h0) begin
        bad++; $display("FAIL rst_mid held: got done=%b data=%h", done_out, lu_data_out);
      end
    end
    rst_n_in = 1'b1;
    model_lu_data = 32'h0;
    @(negedge clk_in);
    total++;
    if (done_out !== 1'b0) begin
      bad++; $display("FAIL rst_mid no done after release: got %b", done_out);
    end
    run_xfer(1'b0, 32'h500, $urandom, 2'b10, 1'b0, 0, 1, 1'b0, 32'h0BADC0DE, "after_rst");
  endtask

  initial begin
    rst_n_in = 1'b0; req_valid_in = 1'b0; req_write_in = 1'b0; req_addr_in = '0;
    req_wdata_in = '0; req_size_in = 2'b00; req_unsigned_in = 1'b0;
    hrdata_in = '0; hready_in = 1'b1; hresp_in = 1'b0;
    test_reset();
    test_load_word();
    test_byte_wait();
    test_store_half();
    test_error();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
